conv_operand_loader: RTL
========================

# conv_operand_loader

Upstream stage of the circular-convolution core: accepts a serial stream of signed samples over a valid/ready handshake, assembles them into the parallel operand arrays A (size_n entries) and B (size_m entries), then pulses `start` for one cycle. It holds both arrays stable while the core runs. It refuses new input until a fixed hold-off has elapsed, then accepts the next frame. Malformed frames are padded or truncated, and `frame_err` is flagged.

## Interface
- size_n, 4, number of A samples per frame
- size_m, 4, number of B samples per frame
- width, 8, sample width in bits (signed)
- hold_cycles, 3, cycles the arrays are held after `start`; must be ≥ 1 and ≥ the core's latency
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  sample present on in_data
- in_data  in  signed [width-1:0]  input sample
- in_last  in  1  marks the final sample of a frame
- in_ready  out  1  loader can accept a sample this cycle
- A  out  signed [width-1:0] x size_n  operand array A, registered
- B  out  signed [width-1:0] x size_m  operand array B, registered
- start  out  1  one-cycle pulse; A/B valid and frozen
- busy  out  1  high in FIRE and HOLD
- frame_err  out  1  one-cycle pulse, coincident with `start`, when the frame length was wrong

## Operation
- Transfer occurs when in_valid && in_ready. No transfer occurs otherwise; in_data is ignored.
- The FSM has four states: LOAD_A, LOAD_B, FIRE and HOLD. A single index counter `idx` runs from 0 to max(size_n,size_m)-1.
- LOAD_A: in_ready=1. Each transfer writes A[idx] and increments idx.
  - On a transfer with idx==size_n-1: clear idx and go to LOAD_B.
  - On a transfer with in_last=1 in LOAD_A: zero A[idx+1..size_n-1] and all of B, set the error flag, and go to FIRE.
- LOAD_B: in_ready=1. Each transfer writes B[idx] and increments idx.
  - On a transfer with in_last=1 before idx==size_m-1: zero B[idx+1..size_m-1], set the error flag, and go to FIRE.
  - On a transfer with idx==size_m-1: go to FIRE. If in_last=0 on that sample, set the error flag; subsequent samples belong to the next frame.
- FIRE: in_ready=0, start=1, frame_err=error flag. Clear the error flag, load the hold counter with hold_cycles, and go to HOLD.
- HOLD: in_ready=0. Decrement the hold counter each cycle. When it reaches 1, clear idx and go to LOAD_A.
- A and B change only on a transfer or a zero-fill. They are otherwise stable, including through FIRE, HOLD and idle periods in LOAD_A.
- Arithmetic: no arithmetic on sample data, which is stored bit-exact. Counter widths are $clog2(max(size_n,size_m)+1) and $clog2(hold_cycles+1).

## Timing
- Reset (reset==0 at a clk edge) sets state=LOAD_A, idx=0, hold counter=0, error flag=0, A and B all zero, start=0, busy=0, frame_err=0, in_ready=1 on the following cycle.
- Reset mid-frame or mid-HOLD discards the partial frame and any pending hold-off. Reset has priority over every transfer in the same cycle.
- in_ready and busy are decoded from the registered state only, with no combinational path from in_valid.
- Final B transfer at edge t → start=1 in cycle t+1 → busy=1 for cycles t+1 .. t+1+hold_cycles → in_ready=1 from cycle t+2+hold_cycles.
- Minimum frame period is size_n+size_m+1+hold_cycles cycles.
- in_valid may be deasserted at any point. The loader waits indefinitely with partial contents retained.

## Structure
- Shared package conv_pkg holds:
  - the loader state enum (LOAD_A, LOAD_B, FIRE, HOLD), encoded on 2 bits;
  - default constants SIZE_N=4, SIZE_M=4, WIDTH=8, HOLD_CYCLES=3, for reuse by the convolution core and its benches.
- One sub-module is natural: conv_holdoff_timer, a loadable down-counter. Its ports are `load`, `count_in` and `expire`, and it uses the same clk/reset.

## Test plan
- Nominal frame 1,2,3,4 | 5,6,7,8 (in_last on 8), in_valid held high → A={1,2,3,4}, B={5,6,7,8}, start pulses once 1 cycle after the last transfer, frame_err=0, in_ready low exactly 4 cycles.
- Negative and extreme values -128,127,-1,0 | -128,-128,127,127 → stored bit-exact, with no sign corruption.
- Short frame 9,10 with in_last on 10 → A={9,10,0,0}, B={0,0,0,0}, start with frame_err=1; next frame loads cleanly from A[0].
- Missing in_last on the 8th sample, then sample 11 offered during HOLD → in_ready=0, so 11 is not taken until LOAD_A. Start fires with frame_err=1, and 11 lands in A[0] of the next frame.
- Gapped in_valid (one sample every 3 cycles) → same arrays as the nominal case; start is delayed accordingly and arrays are stable across gaps.
- reset=0 asserted after 5 samples, then released → all outputs zero, in_ready=1. A fresh full frame produces correct arrays, with no stale data from before reset.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the circular-convolution core: loader FSM states
// and default geometry reused by the core and its benches.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FIRE   = 2'd2,
    HOLD   = 2'd3
  } loader_state_t;

  localparam int SIZE_N      = 4;
  localparam int SIZE_M      = 4;
  localparam int WIDTH       = 8;
  localparam int HOLD_CYCLES = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_holdoff_timer.sv
// Loadable down-counter; expire is high while the count sits at 1 so the
// owner can leave its wait state on that same edge.
module conv_holdoff_timer
  import conv_pkg::*;
#(
  parameter int hold_cycles = HOLD_CYCLES,
  localparam int CW = $clog2(hold_cycles + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] count_in,
  output logic          expire
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= count_in;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == CW'(1));

endmodule

// File: rtl/conv_operand_loader.sv
// Serial-to-parallel operand loader: assembles A then B from a valid/ready
// stream, pulses start, and holds both arrays through a fixed hold-off.
module conv_operand_loader
  import conv_pkg::*;
#(
  parameter int size_n      = SIZE_N,
  parameter int size_m      = SIZE_M,
  parameter int width       = WIDTH,
  parameter int hold_cycles = HOLD_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [width-1:0] in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic signed [width-1:0] A [size_n],
  output logic signed [width-1:0] B [size_m],
  output logic                    start,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int MAXLEN = max_int(size_n, size_m);
  localparam int IW     = $clog2(MAXLEN + 1);
  localparam int HW     = $clog2(hold_cycles + 1);

  loader_state_t state;
  logic [IW-1:0] idx;
  logic          err_flag;
  logic          hold_expire;
  logic          xfer;
  logic          a_end;
  logic          b_end;

  // Handshake outputs come from the registered state only.
  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign busy      = (state == FIRE) || (state == HOLD);
  assign start     = (state == FIRE);
  assign frame_err = (state == FIRE) && err_flag;

  assign xfer  = in_valid && in_ready;
  assign a_end = (idx == IW'(size_n - 1));
  assign b_end = (idx == IW'(size_m - 1));

  conv_holdoff_timer #(
    .hold_cycles(hold_cycles)
  ) u_holdoff (
    .clk     (clk),
    .reset   (reset),
    .load    (state == FIRE),
    .count_in(HW'(hold_cycles)),
    .expire  (hold_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= LOAD_A;
      idx      <= '0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (xfer) begin
            // in_last on the final A sample is still a short frame: B is empty.
            if (in_last) begin
              err_flag <= 1'b1;
              state    <= FIRE;
            end else if (a_end) begin
              idx   <= '0;
              state <= LOAD_B;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (xfer) begin
            if (b_end) begin
              err_flag <= !in_last;
              state    <= FIRE;
            end else if (in_last) begin
              err_flag <= 1'b1;
              state    <= FIRE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        FIRE: begin
          err_flag <= 1'b0;
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_expire) begin
            idx   <= '0;
            state <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < size_n; i++) A[i] <= '0;
    end else if (state == LOAD_A && xfer) begin
      for (int unsigned i = 0; i < size_n; i++) begin
        if (i == 32'(idx)) begin
          A[i] <= in_data;
        end else if (in_last && i > 32'(idx)) begin
          A[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < size_m; i++) B[i] <= '0;
    end else if (state == LOAD_A && xfer && in_last) begin
      for (int unsigned i = 0; i < size_m; i++) B[i] <= '0;
    end else if (state == LOAD_B && xfer) begin
      for (int unsigned i = 0; i < size_m; i++) begin
        if (i == 32'(idx)) begin
          B[i] <= in_data;
        end else if (in_last && i > 32'(idx)) begin
          B[i] <= '0;
        end
      end
    end
  end

endmodule
